muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle integer multiply/divide unit for the RV32M subset of the integer execution path. It accepts one ALU subcode (IOP_MUL through IOP_REMU) with two operands per transaction over a valid/ready request channel. It runs a radix-2 iterative shift-add multiply or restoring divide, then returns one result with a passthrough destination tag over a valid/ready response channel. Exactly one operation is in flight at a time; flush aborts it for pipeline squash.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
TAG_W, 5, width of the opaque destination tag carried from request to response.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  = (state==IDLE) && !flush && !rst; combinational.
req_op  in  7  alu_op_type subcode.
req_rs1  in  XLEN  operand A (multiplicand/dividend).
req_rs2  in  XLEN  operand B (multiplier/divisor).
req_tag  in  TAG_W  destination tag.
flush  in  1  abort the in-flight operation.
rsp_valid  out  1  result valid.
rsp_ready  in  1  consumer accepts result.
rsp_result  out  XLEN  result.
rsp_tag  out  TAG_W  tag of the accepted request.
rsp_bad_op  out  1  req_op was not a supported RV32M subcode.

Behaviour:
- Accept: on a clock edge where req_valid && req_ready, capture op/rs1/rs2/tag. Inputs are ignored at all other times.
- Supported subcodes: MUL=0x04, MULH=0x05, MULHSU=0x06, MULHU=0x07, DIV=0x08, DIVU=0x09, REM=0x0A, REMU=0x0B.
- Any other value is a bad op, including op[6]=1 (W forms). Result 0, rsp_bad_op=1.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL: on accept of a MUL-class op.
  - IDLE -> DIV: on accept of a DIV-class op, unless a special case applies.
  - IDLE -> DONE: on accept of a bad op or a divide special case (fast path).
  - MUL/DIV -> FIX: after exactly 32 iterations; the 6-bit counter runs 0..31.
  - FIX -> DONE: one cycle, applies sign correction and selects the high/low half or quotient/remainder.
  - DONE -> IDLE: when rsp_ready is high.
- Latency: rsp_valid first rises 34 clocks after the accept edge for iterated ops, 1 clock after for fast paths.
- Multiply:
  - Operate on magnitudes; the product is negated in FIX when the effective signs differ.
  - MUL/MULH treat both operands as signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - Operate on magnitudes; quotients truncate toward zero, and the remainder takes the dividend's sign.
  - DIVU/REMU are unsigned.
- Divide special cases (fast path):
  - rs2==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
- DONE:
  - rsp_valid=1; rsp_result, rsp_tag and rsp_bad_op are held stable until the handshake.
  - rsp_valid drops the cycle after the handshake.
  - Earliest next accept is the cycle after the handshake; no same-cycle turnaround.
- Flush:
  - In any state, the next state is IDLE and rsp_valid becomes 0 next cycle.
  - Flush takes priority over an accept and over a response handshake in the same cycle; the response is discarded.
- Reset (also mid-operation):
  - Next cycle: state=IDLE, counter=0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_bad_op=0.
  - req_ready=0 while rst is high.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> rsp_result=0xFFFFFFEB, rsp_bad_op=0, rsp_valid rises exactly 34 clocks after accept, tag echoed.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Division:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 0x0000000E.
  - REMU 100/7 -> 0x00000002.
- Special cases, each with rsp_valid 1 clock after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- Bad ops: req_op=0x00 (IOP_ADD) and 0x44 (IOP_MULW) -> rsp_bad_op=1, rsp_result=0, 1-clock latency.
- Control: rsp_ready held low for 10 cycles -> outputs stable and req_ready=0 throughout.
  - flush at iteration 10 of a DIV -> no rsp_valid, req_ready=1 next cycle, following MUL 3x4 -> 12.
  - rst at iteration 5 of a MUL -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one operation in flight, valid/ready request and response channels.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_bad_op
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              bad_q, bad_d;

    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic              mul_q, mul_d;
    logic [1:0]        sub_q, sub_d;

    logic              accept, op_ok, op_mul, a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf, fast;
    logic [1:0]        sub;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, fix_res, rem_sel;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;

    assign req_ready  = (state_q == S_IDLE) && !flush && !rst;
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_result = res_q;
    assign rsp_tag    = tag_q;
    assign rsp_bad_op = bad_q;

    // Request decode: signedness, magnitudes and the single-cycle fast paths.
    always_comb begin
        accept   = req_valid && req_ready;
        sub      = req_op[1:0];
        op_ok    = (req_op[6:4] == 3'b000) && ((req_op[3:2] == 2'b01) || (req_op[3:2] == 2'b10));
        op_mul   = (req_op[3:2] == 2'b01);
        a_sgn    = op_mul ? (sub != 2'b11) : !sub[0];
        b_sgn    = op_mul ? !sub[1] : !sub[0];
        a_neg    = a_sgn && req_rs1[XLEN-1];
        b_neg    = b_sgn && req_rs2[XLEN-1];
        mag_a    = cond_neg(req_rs1, a_neg);
        mag_b    = cond_neg(req_rs2, b_neg);
        div_zero = (req_rs2 == '0);
        div_ovf  = !sub[0] && (req_rs1 == INT_MIN) && (req_rs2 == '1);
        fast     = !op_ok || (!op_mul && (div_zero || div_ovf));
        fast_res = '0;
        if (op_ok && div_zero) begin
            fast_res = sub[1] ? req_rs1 : '1;
        end else if (op_ok && div_ovf) begin
            fast_res = sub[1] ? '0 : INT_MIN;
        end
    end

    // One radix-2 step: {hi,lo} shifts right for multiply, left for divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        prod_fix  = cond_neg_wide({hi_q, lo_q}, neg_q);
        rem_sel   = sub_q[1] ? hi_q : lo_q;
        if (mul_q) begin
            fix_res = (sub_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            fix_res = cond_neg(rem_sel, neg_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        tag_d   = tag_q;
        bad_d   = bad_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        neg_d   = neg_q;
        mul_d   = mul_q;
        sub_d   = sub_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tag_d = req_tag;
                        bad_d = !op_ok;
                        mul_d = op_mul;
                        sub_d = sub;
                        hi_d  = '0;
                        cnt_d = '0;
                        if (fast) begin
                            res_d   = fast_res;
                            state_d = S_DONE;
                        end else if (op_mul) begin
                            lo_d    = mag_b;
                            b_d     = mag_a;
                            neg_d   = a_neg ^ b_neg;
                            state_d = S_MUL;
                        end else begin
                            lo_d    = mag_a;
                            b_d     = mag_b;
                            neg_d   = sub[1] ? a_neg : (a_neg ^ b_neg);
                            state_d = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    hi_d  = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
                S_DIV: begin
                    // A clear borrow bit means the shifted remainder covered the divisor.
                    hi_d  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], !div_diff[XLEN]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    res_d   = fix_res;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            bad_q   <= bad_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q  <= hi_d;
        lo_q  <= lo_d;
        b_q   <= b_d;
        neg_q <= neg_d;
        mul_q <= mul_d;
        sub_q <= sub_d;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, stall, flush and reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_op = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_tag;
    logic        rsp_bad_op;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_bad_op(rsp_bad_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input string name, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_res,
                          input logic exp_bad, input int exp_lat);
        int lat;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
        #1;
        chk({name, "_req_ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, 64'(rsp_result), 64'(exp_res));
        chk({name, "_tag"}, 64'(rsp_tag), 64'(tag));
        chk({name, "_bad_op"}, 64'(rsp_bad_op), 64'(exp_bad));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_valid_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int  lat;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_result", 64'(rsp_result), 64'd0);
        chk("rst_tag", 64'(rsp_tag), 64'd0);
        chk("rst_bad", 64'(rsp_bad_op), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // Multiplies
        run_op("mul",    7'h04, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0, 34);
        run_op("mulh",   7'h05, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 1'b0, 34);
        run_op("mulhsu", 7'h06, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF, 1'b0, 34);
        run_op("mulhu",  7'h07, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 1'b0, 34);

        // Divides
        run_op("div",  7'h08, 32'hFFFFFFF9, 32'd2, 5'd9,  32'hFFFFFFFD, 1'b0, 34);
        run_op("rem",  7'h0A, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 1'b0, 34);
        run_op("divu", 7'h09, 32'd100,      32'd7, 5'd11, 32'h0000000E, 1'b0, 34);
        run_op("remu", 7'h0B, 32'd100,      32'd7, 5'd12, 32'h00000002, 1'b0, 34);

        // Divide special cases
        run_op("divu_z", 7'h09, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1'b0, 1);
        run_op("rem_z",  7'h0A, 32'd5,        32'd0,        5'd14, 32'd5,        1'b0, 1);
        run_op("div_ov", 7'h08, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b0, 1);
        run_op("rem_ov", 7'h0A, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1'b0, 1);

        // Unsupported subcodes
        run_op("bad_add",  7'h00, 32'd3, 32'd4, 5'd17, 32'd0, 1'b1, 1);
        run_op("bad_mulw", 7'h44, 32'd3, 32'd4, 5'd18, 32'd0, 1'b1, 1);

        // Response back-pressure with a competing request held on the input
        req_valid = 1'b1; req_op = 7'h09; req_rs1 = 32'd100; req_rs2 = 32'd7; req_tag = 5'd19;
        @(negedge clk);
        req_op = 7'h04; req_rs1 = 32'd2; req_rs2 = 32'd2; req_tag = 5'd2;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("stall_latency", 64'(lat), 64'd34);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_result", 64'(rsp_result), 64'h0000000E);
            chk("stall_tag", 64'(rsp_tag), 64'd19);
            chk("stall_bad", 64'(rsp_bad_op), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_valid_drop", 64'(rsp_valid), 64'd0);
        chk("stall_next_ready", 64'(req_ready), 64'd1);

        // Flush part way through a divide
        req_valid = 1'b1; req_op = 7'h08; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_tag = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("flush_req_ready_after", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("flush_no_response", 64'(seen), 64'd0);
        run_op("mul_after_flush", 7'h04, 32'd3, 32'd4, 5'd31, 32'd12, 1'b0, 34);

        // Reset part way through a multiply
        req_valid = 1'b1; req_op = 7'h04; req_rs1 = 32'd9; req_rs2 = 32'd9; req_tag = 5'd21;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("midrst_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_result", 64'(rsp_result), 64'd0);
        chk("midrst_tag", 64'(rsp_tag), 64'd0);
        chk("midrst_bad", 64'(rsp_bad_op), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        run_op("mulhu_after_rst", 7'h07, 32'hFFFFFFFF, 32'd2, 5'd3, 32'd1, 1'b0, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
